// File: rtl/vm_pkg.sv
// Shared definitions for the change dispenser: coin denominations, state encoding
// and the code-to-value lookup.
package vm_pkg;

    localparam int NUM_DENOM = 5;

    typedef enum logic [2:0] {
        COIN_1  = 3'd0,
        COIN_5  = 3'd1,
        COIN_10 = 3'd2,
        COIN_20 = 3'd3,
        COIN_50 = 3'd4
    } coin_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic [5:0] denom_value(input logic [2:0] code);
        case (code)
            COIN_1:  denom_value = 6'd1;
            COIN_5:  denom_value = 6'd5;
            COIN_10: denom_value = 6'd10;
            COIN_20: denom_value = 6'd20;
            COIN_50: denom_value = 6'd50;
            default: denom_value = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: largest denomination that fits the remaining
// amount and still has stock.
module coin_select
    import vm_pkg::*;
#(
    parameter int AMT_W = 6
) (
    input  logic [AMT_W-1:0]     remaining_i,
    input  logic [NUM_DENOM-1:0] avail_i,
    output logic                 found_o,
    output logic [2:0]           code_o,
    output logic [AMT_W-1:0]     value_o
);

    // Ascending scan, so the last qualifying denomination (the largest) wins.
    always_comb begin
        found_o = 1'b0;
        code_o  = 3'd0;
        value_o = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (avail_i[i] && (int'(denom_value(3'(i))) <= int'(remaining_i))) begin
                found_o = 1'b1;
                code_o  = 3'(i);
                value_o = AMT_W'(denom_value(3'(i)));
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount out as single coins over a valid/ready handshake, tracking
// per-denomination inventory. Optional stall abort: define DISPENSE_TIMEOUT_EN.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W       = 6,
    parameter int INV_W       = 4,
    parameter int INIT_COUNT  = 15,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             refill,
    output logic             coin_valid,
    output logic [2:0]       coin_type,
    input  logic             coin_ready,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic             timeout
);

    if (INIT_COUNT < 0 || INIT_COUNT >= (1 << INV_W) || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("change_dispenser: INIT_COUNT must fit INV_W and TIMEOUT_CYC must be positive");
    end

    localparam logic [INV_W-1:0] INIT_INV = INV_W'(INIT_COUNT);

    state_e               state_q, state_d;
    logic [AMT_W-1:0]     remain_q, remain_d;
    logic [INV_W-1:0]     inv_q [NUM_DENOM];
    logic [INV_W-1:0]     inv_d [NUM_DENOM];
    logic                 coin_valid_q, coin_valid_d;
    logic [2:0]           coin_type_q, coin_type_d;
    logic [AMT_W-1:0]     coin_val_q, coin_val_d;
    logic                 done_q, done_d;
    logic [AMT_W-1:0]     short_q, short_d;

    logic [NUM_DENOM-1:0] avail;
    logic                 sel_found;
    logic [2:0]           sel_code;
    logic [AMT_W-1:0]     sel_value;

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]     stall_q, stall_d;
    logic                 abort_q, abort_d;
    logic                 timeout_q, timeout_d;
`endif

    always_comb begin
        for (int i = 0; i < NUM_DENOM; i++) avail[i] = (inv_q[i] != '0);
    end

    coin_select #(.AMT_W(AMT_W)) u_coin_select (
        .remaining_i (remain_q),
        .avail_i     (avail),
        .found_o     (sel_found),
        .code_o      (sel_code),
        .value_o     (sel_value)
    );

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        inv_d        = inv_q;
        coin_valid_d = coin_valid_q;
        coin_type_d  = coin_type_q;
        coin_val_d   = coin_val_q;
        done_d       = 1'b0;
        short_d      = short_q;
`ifdef DISPENSE_TIMEOUT_EN
        stall_d      = stall_q;
        abort_d      = abort_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (refill) begin
                    for (int i = 0; i < NUM_DENOM; i++) inv_d[i] = INIT_INV;
                end else if (req_valid) begin
                    remain_d = req_amount;
                    state_d  = (req_amount == '0) ? ST_DONE : ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (sel_found) begin
                    coin_valid_d = 1'b1;
                    coin_type_d  = sel_code;
                    coin_val_d   = sel_value;
                    state_d      = ST_ISSUE;
`ifdef DISPENSE_TIMEOUT_EN
                    stall_d      = '0;
`endif
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (coin_ready) begin
                    remain_d = remain_q - coin_val_q;
                    for (int i = 0; i < NUM_DENOM; i++) begin
                        if (coin_type_q == 3'(i)) inv_d[i] = inv_q[i] - 1'b1;
                    end
                    coin_valid_d = 1'b0;
                    state_d      = (remain_q == coin_val_q) ? ST_DONE : ST_SELECT;
                end
`ifdef DISPENSE_TIMEOUT_EN
                // The unaccepted coin stays in inventory and in the remainder.
                else if (stall_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    coin_valid_d = 1'b0;
                    abort_d      = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                done_d  = 1'b1;
                short_d = remain_q;
                state_d = ST_IDLE;
`ifdef DISPENSE_TIMEOUT_EN
                timeout_d = abort_q;
                abort_d   = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            remain_q     <= '0;
            for (int i = 0; i < NUM_DENOM; i++) inv_q[i] <= INIT_INV;
            coin_valid_q <= 1'b0;
            coin_type_q  <= 3'd0;
            coin_val_q   <= '0;
            done_q       <= 1'b0;
            short_q      <= '0;
`ifdef DISPENSE_TIMEOUT_EN
            stall_q      <= '0;
            abort_q      <= 1'b0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            inv_q        <= inv_d;
            coin_valid_q <= coin_valid_d;
            coin_type_q  <= coin_type_d;
            coin_val_q   <= coin_val_d;
            done_q       <= done_d;
            short_q      <= short_d;
`ifdef DISPENSE_TIMEOUT_EN
            stall_q      <= stall_d;
            abort_q      <= abort_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !refill;
    assign busy       = (state_q != ST_IDLE);
    assign coin_valid = coin_valid_q;
    assign coin_type  = coin_type_q;
    assign done       = done_q;
    assign shortfall  = short_q;
`ifdef DISPENSE_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a default-stock instance and a single-coin-stock
// instance, each checked by a coin/done scoreboard.
module tb_change_dispenser;

    localparam int AMT_W = 6;
    localparam int INV_W = 4;
    localparam int TCYC  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;

    logic             a_req_valid = 1'b0, a_refill = 1'b0, a_coin_ready = 1'b1;
    logic [AMT_W-1:0] a_req_amount = '0;
    logic             a_req_ready, a_coin_valid, a_busy, a_done, a_timeout;
    logic [2:0]       a_coin_type;
    logic [AMT_W-1:0] a_shortfall;

    logic             b_req_valid = 1'b0, b_refill = 1'b0, b_coin_ready = 1'b1;
    logic [AMT_W-1:0] b_req_amount = '0;
    logic             b_req_ready, b_coin_valid, b_busy, b_done, b_timeout;
    logic [2:0]       b_coin_type;
    logic [AMT_W-1:0] b_shortfall;

    change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W), .INIT_COUNT(15), .TIMEOUT_CYC(TCYC)) dut_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_amount(a_req_amount),
        .req_ready(a_req_ready), .refill(a_refill), .coin_valid(a_coin_valid),
        .coin_type(a_coin_type), .coin_ready(a_coin_ready), .busy(a_busy), .done(a_done),
        .shortfall(a_shortfall), .timeout(a_timeout));

    change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W), .INIT_COUNT(1), .TIMEOUT_CYC(TCYC)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_amount(b_req_amount),
        .req_ready(b_req_ready), .refill(b_refill), .coin_valid(b_coin_valid),
        .coin_type(b_coin_type), .coin_ready(b_coin_ready), .busy(b_busy), .done(b_done),
        .shortfall(b_shortfall), .timeout(b_timeout));

    int checks = 0;
    int errors = 0;

    typedef struct { int shortf; int tmo; } done_exp_t;
    int        coin_q_a[$];
    int        coin_q_b[$];
    done_exp_t done_q_a[$];
    done_exp_t done_q_b[$];
    int        done_cnt_a = 0;
    int        done_cnt_b = 0;
    int        rmode_a = 0;  // 0: ready high, 1: random, 2: held low
    int        rmode_b = 0;
    int        exp_inv[5] = '{15, 15, 15, 15, 15};

    typedef struct { int amt; int n; int coins[6]; int shortf; int rmode; } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            a_coin_ready = (rmode_a == 0) ? 1'b1 : (rmode_a == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            b_coin_ready = (rmode_b == 0) ? 1'b1 : (rmode_b == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin : mon_a
        done_exp_t d;
        if (reset) begin
            if (a_coin_valid && a_coin_ready) begin
                if (coin_q_a.size() == 0) flag("a_unexpected_coin");
                else check("a_coin_type", int'(a_coin_type), coin_q_a.pop_front());
            end
            if (a_done) begin
                done_cnt_a++;
                if (done_q_a.size() == 0) flag("a_unexpected_done");
                else begin
                    d = done_q_a.pop_front();
                    check("a_shortfall", int'(a_shortfall), d.shortf);
                    check("a_timeout", int'(a_timeout), d.tmo);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        done_exp_t d;
        if (reset) begin
            if (b_coin_valid && b_coin_ready) begin
                if (coin_q_b.size() == 0) flag("b_unexpected_coin");
                else check("b_coin_type", int'(b_coin_type), coin_q_b.pop_front());
            end
            if (b_done) begin
                done_cnt_b++;
                if (done_q_b.size() == 0) flag("b_unexpected_done");
                else begin
                    d = done_q_b.pop_front();
                    check("b_shortfall", int'(b_shortfall), d.shortf);
                    check("b_timeout", int'(b_timeout), d.tmo);
                end
            end
        end
    end

    task automatic send(input int sel, input int amt);
        int k;
        k = 0;
        @(negedge clk);
        while (((sel == 0) ? a_req_ready : b_req_ready) == 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_before_send", int'((sel == 0) ? a_req_ready : b_req_ready), 1);
        if (sel == 0) begin a_req_valid = 1'b1; a_req_amount = AMT_W'(amt); end
        else          begin b_req_valid = 1'b1; b_req_amount = AMT_W'(amt); end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int start);
        int k;
        k = 0;
        while (((sel == 0) ? done_cnt_a : done_cnt_b) == start && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("done_arrived", ((sel == 0) ? done_cnt_a : done_cnt_b) - start, 1);
        check("coins_left", (sel == 0) ? coin_q_a.size() : coin_q_b.size(), 0);
    endtask

    task automatic wait_coin_valid(input int sel);
        int k;
        k = 0;
        while (((sel == 0) ? a_coin_valid : b_coin_valid) == 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("coin_valid_seen", int'((sel == 0) ? a_coin_valid : b_coin_valid), 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s;
        vecs[0] = '{40, 2, '{3, 3, 0, 0, 0, 0}, 0, 0};
        vecs[1] = '{36, 4, '{3, 2, 1, 0, 0, 0}, 0, 0};
        vecs[2] = '{63, 5, '{4, 2, 0, 0, 0, 0}, 0, 1};
        vecs[3] = '{55, 2, '{4, 1, 0, 0, 0, 0}, 0, 1};
        vecs[4] = '{1,  1, '{0, 0, 0, 0, 0, 0}, 0, 0};
        vecs[5] = '{48, 6, '{3, 3, 1, 0, 0, 0}, 0, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_coin_valid", int'(a_coin_valid), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_shortfall", int'(a_shortfall), 0);
        check("rst_timeout", int'(a_timeout), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_req_ready", int'(a_req_ready), 1);
        check("rst_coin_type", int'(a_coin_type), 0);
        reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            rmode_a = vecs[v].rmode;
            for (int c = 0; c < vecs[v].n; c++) begin
                coin_q_a.push_back(vecs[v].coins[c]);
                exp_inv[vecs[v].coins[c]]--;
            end
            done_q_a.push_back('{vecs[v].shortf, 0});
            s = done_cnt_a;
            send(0, vecs[v].amt);
            wait_done(0, s);
            if (v == 0) check("a_inv20_after_40", int'(dut_a.inv_q[3]), 13);
        end
        rmode_a = 0;
        for (int i = 0; i < 5; i++) check("a_inv_after_table", int'(dut_a.inv_q[i]), exp_inv[i]);

        done_q_a.push_back('{0, 0});
        s = done_cnt_a;
        send(0, 0);
        @(negedge clk);
        check("zero_busy_done_state", int'(a_busy), 1);
        check("zero_done_not_yet", int'(a_done), 0);
        @(negedge clk);
        check("zero_done_pulse", int'(a_done), 1);
        wait_done(0, s);
        @(negedge clk);
        check("zero_done_one_cycle", int'(a_done), 0);

        rmode_a = 2;
        coin_q_a.push_back(4);
        done_q_a.push_back('{0, 0});
        s = done_cnt_a;
        send(0, 50);
        wait_coin_valid(0);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", int'(a_coin_valid), 1);
            check("stall_type", int'(a_coin_type), 4);
            check("stall_inv50", int'(dut_a.inv_q[4]), exp_inv[4]);
            @(negedge clk);
        end
        rmode_a = 0;
        exp_inv[4]--;
        wait_done(0, s);
        check("stall_inv50_after", int'(dut_a.inv_q[4]), exp_inv[4]);

        coin_q_b = '{3, 2, 1, 0};
        done_q_b.push_back('{4, 0});
        s = done_cnt_b;
        send(1, 40);
        wait_done(1, s);
        check("b_inv20_empty", int'(dut_b.inv_q[3]), 0);
        check("b_inv50_kept", int'(dut_b.inv_q[4]), 1);
        @(negedge clk);
        b_refill = 1'b1;
        #1;
        check("b_ready_low_refill", int'(b_req_ready), 0);
        @(posedge clk);
        #1;
        b_refill = 1'b0;
        check("b_inv20_refilled", int'(dut_b.inv_q[3]), 1);
        coin_q_b.push_back(3);
        done_q_b.push_back('{0, 0});
        s = done_cnt_b;
        send(1, 20);
        wait_done(1, s);

        rmode_b = 2;
        coin_q_b.push_back(1);
        done_q_b.push_back('{0, 0});
        s = done_cnt_b;
        send(1, 5);
        wait_coin_valid(1);
        b_refill = 1'b1;
        @(negedge clk);
        b_refill = 1'b0;
        rmode_b = 0;
        wait_done(1, s);
        check("b_refill_ignored_busy", int'(dut_b.inv_q[1]), 0);

        rmode_a = 2;
        coin_q_a.push_back(3);
        send(0, 20);
        wait_coin_valid(0);
        reset = 1'b0;
        coin_q_a.delete();
        @(negedge clk);
        check("mid_rst_coin_valid", int'(a_coin_valid), 0);
        check("mid_rst_busy", int'(a_busy), 0);
        check("mid_rst_done", int'(a_done), 0);
        for (int i = 0; i < 5; i++) begin
            check("mid_rst_inv", int'(dut_a.inv_q[i]), 15);
            exp_inv[i] = 15;
        end
        reset = 1'b1;
        rmode_a = 0;
        repeat (6) @(negedge clk);

        coin_q_a = '{3, 3};
        done_q_a.push_back('{0, 0});
        exp_inv[3] -= 2;
        s = done_cnt_a;
        send(0, 40);
        wait_done(0, s);

`ifdef DISPENSE_TIMEOUT_EN
        rmode_a = 2;
        done_q_a.push_back('{30, 1});
        s = done_cnt_a;
        send(0, 30);
        wait_done(0, s);
        rmode_a = 0;
        check("tmo_inv20_kept", int'(dut_a.inv_q[3]), exp_inv[3]);
        check("tmo_coin_valid", int'(a_coin_valid), 0);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
